// File: rtl/approx_prod_div.sv
// Sequential 16/8 restoring divider that recovers an 8-bit operand from an 8x8 product.
// Optional recovery check (expected operand vs. quotient) is enabled with APPROX_RECOVER_CHK_EN.

module approx_prod_div_step #(
    parameter int DVW = 8
) (
    input  logic [DVW-1:0] rem_in,
    input  logic           bit_in,
    input  logic [DVW-1:0] dvs,
    output logic [DVW-1:0] rem_out,
    output logic           qbit
);
    logic [DVW:0] trial;
    logic [DVW:0] diff;

    // 9-bit trial value keeps the carry for divisors >= 128
    assign trial   = {rem_in, bit_in};
    assign diff    = trial - {1'b0, dvs};
    assign qbit    = (trial >= {1'b0, dvs});
    assign rem_out = qbit ? diff[DVW-1:0] : trial[DVW-1:0];
endmodule

module approx_prod_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero
`ifdef APPROX_RECOVER_CHK_EN
    ,
    input  logic [7:0]  expected,
    output logic        mismatch
`endif
);
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [DW-1:0] dvd;
        logic [VW-1:0] dvs;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] quo;
        logic [VW-1:0] rem;
        logic          dz;
    } rsp_t;

    state_t        state, nstate;
    req_t          op;
    rsp_t          rsp_q;
    logic [CW-1:0] cnt;
    logic [VW-1:0] wrem;
    logic [DW-1:0] wquo;
    logic [VW-1:0] rem_nxt;
    logic          qbit;
    logic [DW-1:0] quo_nxt;
    logic          accept;
    logic          last;

    assign accept  = in_valid && in_ready;
    assign last    = (cnt == CW'(DW - 1));
    assign quo_nxt = {wquo[DW-2:0], qbit};

    approx_prod_div_step #(.DVW(VW)) u_step (
        .rem_in  (wrem),
        .bit_in  (op.dvd[DW-1]),
        .dvs     (op.dvs),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (accept) nstate = (divisor == '0) ? DONE : CALC;
            CALC:    if (last) nstate = DONE;
            DONE:    if (out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= '0;
            rsp_q <= '0;
            cnt   <= '0;
            wrem  <= '0;
            wquo  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op.dvd <= dividend;
                        op.dvs <= divisor;
                        cnt    <= '0;
                        wrem   <= '0;
                        wquo   <= '0;
                        if (divisor == '0) begin
                            rsp_q.quo <= '1;
                            rsp_q.rem <= dividend[VW-1:0];
                            rsp_q.dz  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    op.dvd <= {op.dvd[DW-2:0], 1'b0};
                    wrem   <= rem_nxt;
                    wquo   <= quo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        rsp_q.quo <= quo_nxt;
                        rsp_q.rem <= rem_nxt;
                        rsp_q.dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = rsp_q.quo;
    assign remainder = rsp_q.rem;
    assign div_zero  = rsp_q.dz;

`ifdef APPROX_RECOVER_CHK_EN
    logic [VW-1:0] exp_q;

    // A recovered operand must fit in 8 bits and equal the expected value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q    <= '0;
            mismatch <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                exp_q <= expected;
                if (divisor == '0) mismatch <= 1'b1;
            end else if (state == CALC && last) begin
                mismatch <= (quo_nxt[DW-1:VW] != '0) || (quo_nxt[VW-1:0] != exp_q);
            end
        end
    end
`endif
endmodule

// File: doc/approx_prod_div.md
APPROX_PROD_DIV -- requirements
Module: approx_prod_div

Interface
REQ-001 The block SHALL be a single-clock, sequential 16/8 restoring divider that recovers an operand from an 8x8 product; one clock, reset asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  dividend/divisor present.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  16  unsigned product, e.g. an 8x8 multiplier output.
REQ-007 divisor  input  8  unsigned divisor.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  16  unsigned quotient.
REQ-011 remainder  output  8  unsigned remainder.
REQ-012 div_zero  output  1  result came from divisor == 0.

Function
REQ-013 FSM SHALL have states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE: in_valid && in_ready at an edge SHALL capture dividend and divisor and enter CALC with iteration count 0, or enter DONE directly if divisor == 0.
REQ-015 CALC SHALL perform one restoring iteration per edge, MSB first: shift remainder left, insert the next dividend bit, then subtract the divisor and set the quotient bit when the 9-bit partial remainder >= divisor.
REQ-016 The partial remainder SHALL be 9 bits wide, so no carry is lost for any divisor.
REQ-017 After the 16th iteration edge, FSM SHALL enter DONE; out_valid SHALL rise exactly 16 edges after the accept edge.
REQ-018 Results SHALL be exact: quotient = floor(dividend/divisor), remainder = dividend mod divisor.
REQ-019 Divisor == 0 SHALL give quotient = 16'hFFFF, remainder = dividend[7:0], div_zero = 1, out_valid one edge after accept.
REQ-020 div_zero SHALL be 0 for every nonzero-divisor result.
REQ-021 DONE SHALL hold quotient, remainder and div_zero stable while out_valid && !out_ready.
REQ-022 out_valid && out_ready SHALL return FSM to IDLE; no new operation is accepted in that same cycle.
REQ-023 in_valid during CALC/DONE SHALL be ignored, and dividend/divisor changes SHALL not affect the operation in flight.
REQ-024 Outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready = 1 after release, out_valid = 0, quotient = 0, remainder = 0, div_zero = 0, and clear internal counters.
REQ-026 Reset during CALC or DONE SHALL abort the operation with no result produced after release.

Configuration
REQ-027 Macro APPROX_RECOVER_CHK_EN SHALL, when defined, add input expect (8 bits, captured at accept) and output mismatch (1 bit, registered, valid with out_valid).
REQ-028 mismatch SHALL be 1 iff div_zero, quotient[15:8] != 0, or quotient[7:0] != captured expect; it resets to 0.
REQ-029 With the macro undefined, these ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 dividend 0x0D2F, divisor 0x0F -> out_valid 16 edges after accept, quotient 0x00E1, remainder 0x00, div_zero 0.
REQ-031 0x03E8/0x07 -> quotient 0x008E, remainder 0x06; 0xFFFF/0x01 -> quotient 0xFFFF, remainder 0x00.
REQ-032 divisor 0x00, dividend 0x1234 -> one edge later quotient 0xFFFF, remainder 0x34, div_zero 1.
REQ-033 Hold out_ready = 0 for 5 cycles after 0xFFFF/0xFF -> quotient 0x0101 and remainder 0x00 stable throughout, in_ready 0; then out_ready = 1 -> IDLE the next cycle.
REQ-034 Pull rst_n low at iteration 8, toggle in_valid during CALC -> out_valid stays 0, and the next operation is accepted normally after release.
REQ-035 With APPROX_RECOVER_CHK_EN: 0x0D2F/0x0F with expect 0xE1 -> mismatch 0; expect 0xE0 -> mismatch 1.
